// File: rtl/exe_muldiv_unit_if.sv
// Execute-stage link between the D/E pipeline register and the RV32M
// multiply/divide unit.
//   master: pipeline side, drives flush/in_valid/func3/operands/rd_index and
//           receives stall/done/result/rd_out
//   slave : muldiv unit side
interface exe_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_index;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output flush, in_valid, func3, rs1_val, rs2_val, rd_index,
    input  stall, done, result, rd_out
  );

  modport slave (
    input  flush, in_valid, func3, rs1_val, rs2_val, rd_index,
    output stall, done, result, rd_out
  );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
//   clk, rst (async, active-low)
//   bus.flush     : abort the E-stage instruction
//   bus.in_valid  : M-extension instruction present in E
//   bus.func3     : MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   bus.rs1_val/rs2_val/rd_index : forwarded operands and destination
//   bus.stall     : combinational hold of PC, F/D and D/E
//   bus.done      : one-cycle result-valid pulse (registered)
//   bus.result/rd_out : result and destination, held until the next done
module exe_muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input logic             clk,
  input logic             rst,
  exe_muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(ITER) + 1;
  localparam int unsigned DW = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      func3_q, func3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  // Start decode: signedness, magnitudes and fast-path detection
  logic            s1_signed, s2_signed, neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            is_div, div_zero, div_ovf;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    s1_signed   = (bus.func3 == 3'b000) || (bus.func3 == 3'b001) ||
                  (bus.func3 == 3'b010) || (bus.func3 == 3'b100) ||
                  (bus.func3 == 3'b110);
    s2_signed   = (bus.func3 == 3'b000) || (bus.func3 == 3'b001) ||
                  (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
    neg1        = s1_signed && bus.rs1_val[XLEN-1];
    neg2        = s2_signed && bus.rs2_val[XLEN-1];
    mag1        = neg1 ? (~bus.rs1_val + XLEN'(1)) : bus.rs1_val;
    mag2        = neg2 ? (~bus.rs2_val + XLEN'(1)) : bus.rs2_val;
    is_div      = bus.func3[2];
    div_zero    = is_div && (bus.rs2_val == '0);
    div_ovf     = is_div && !bus.func3[0] && (bus.rs1_val == INT_MIN) &&
                  (bus.rs2_val == '1);
    // func3[1] selects remainder over quotient
    if (div_zero) begin
      fast_result = bus.func3[1] ? bus.rs1_val : '1;
    end else begin
      fast_result = bus.func3[1] ? '0 : INT_MIN;
    end
  end

  // One iteration: shift-add multiply or restoring divide on acc_q
  logic [XLEN:0]   mul_sum;
  logic [DW-1:0]   mul_next;
  logic [XLEN:0]   div_shift, div_diff;
  logic [DW-1:0]   div_next;
  logic [DW-1:0]   iter_next;
  logic [DW-1:0]   prod;
  logic [XLEN-1:0] quo, rem;
  logic [XLEN-1:0] calc_result;

  always_comb begin
    // acc = {partial product high, multiplier shifting out}
    mul_sum   = {1'b0, acc_q[DW-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // acc = {partial remainder, dividend shifting out / quotient shifting in}
    div_shift = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    iter_next = func3_q[2] ? div_next : mul_next;

    prod = neg_res_q ? (~iter_next + DW'(1)) : iter_next;
    quo  = neg_res_q ? (~iter_next[XLEN-1:0] + XLEN'(1)) : iter_next[XLEN-1:0];
    rem  = neg_rem_q ? (~iter_next[DW-1:XLEN] + XLEN'(1)) : iter_next[DW-1:XLEN];

    if (func3_q[2]) begin
      calc_result = func3_q[1] ? rem : quo;
    end else begin
      calc_result = (func3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[DW-1:XLEN];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func3_d   = func3_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          func3_d   = bus.func3;
          rd_d      = bus.rd_index;
          neg_res_d = neg1 ^ neg2;
          neg_rem_d = neg1;
          cnt_d     = '0;
          if (is_div) begin
            opnd_d = mag2;
            acc_d  = {{XLEN{1'b0}}, mag1};
          end else begin
            opnd_d = mag1;
            acc_d  = {{XLEN{1'b0}}, mag2};
          end
          if (div_zero || div_ovf) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = fast_result;
            rd_out_d = bus.rd_index;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = iter_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = calc_result;
            rd_out_d = rd_q;
          end
        end
      end
      DONE: begin
        // in_valid still shows the finished instruction; never restart here
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      func3_q   <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func3_q   <= func3_d;
      rd_q      <= rd_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign bus.stall  = ((state_q == IDLE) && bus.in_valid && !bus.flush) ||
                      (state_q == CALC);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
module tb_exe_muldiv_unit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [36:0] exp_q[$];

  exe_muldiv_unit_if bus_if ();

  exe_muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference semantics of RV32M computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Every done pulse must deliver the oldest outstanding expected result
  always @(negedge clk) begin
    if (rst && bus_if.done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: actual done=1 required done=0 (result=%h)",
                 bus_if.result);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("done_result", 64'(bus_if.result), 64'(e[31:0]));
        check("done_rd_out", 64'(bus_if.rd_out), 64'(e[36:32]));
      end
    end
  end

  task automatic idle_inputs();
    bus_if.in_valid = 1'b0;
    bus_if.flush    = 1'b0;
    bus_if.func3    = 3'($urandom);
    bus_if.rs1_val  = 32'($urandom);
    bus_if.rs2_val  = 32'($urandom);
    bus_if.rd_index = 5'($urandom);
  endtask

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    bus_if.in_valid = 1'b1;
    bus_if.flush    = 1'b0;
    bus_if.func3    = f;
    bus_if.rs1_val  = a;
    bus_if.rs2_val  = b;
    bus_if.rd_index = rd;
  endtask

  // Issue one op and check cycle-by-cycle stall/done timing plus result hold
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit use_lit, input logic [31:0] lit);
    logic [31:0] e;
    bit fast;
    int lat;
    e    = use_lit ? lit : ref_op(f, a, b);
    fast = f[2] && (b == 32'd0 ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    lat  = fast ? 1 : 33;
    @(posedge clk); #1;
    start_op(f, a, b, rd);
    exp_q.push_back({rd, e});
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      check($sformatf("stall f%0d c%0d", f, k), 64'(bus_if.stall), 64'(k < lat));
      check($sformatf("done f%0d c%0d", f, k), 64'(bus_if.done), 64'(k == lat));
      if (k == lat + 1) begin
        check("result_hold", 64'(bus_if.result), 64'(e));
        check("rd_out_hold", 64'(bus_if.rd_out), 64'(rd));
      end
      if (k <= lat) begin
        @(posedge clk); #1;
        if (k == lat) idle_inputs();
      end
    end
  endtask

  // Start a division and abort it in cycle 10 by flush (abort=0) or reset (abort=1)
  task automatic run_abort(input bit use_rst);
    @(posedge clk); #1;
    start_op(3'd4, 32'd1000, 32'd7, 5'd9);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("abort stall c%0d", k), 64'(bus_if.stall), 64'd1);
      @(posedge clk); #1;
    end
    if (use_rst) begin
      rst             = 1'b0;
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      check("rst_stall", 64'(bus_if.stall), 64'd0);
      check("rst_done", 64'(bus_if.done), 64'd0);
      check("rst_result", 64'(bus_if.result), 64'd0);
      check("rst_rd_out", 64'(bus_if.rd_out), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
    end else begin
      bus_if.flush = 1'b1;
      @(negedge clk);
      check("flush_stall c10", 64'(bus_if.stall), 64'd1);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("flush_stall c11", 64'(bus_if.stall), 64'd0);
      check("flush_done c11", 64'(bus_if.done), 64'd0);
    end
    // Any done in the following window is reported by the monitor
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset_stall", 64'(bus_if.stall), 64'd0);
    check("reset_done", 64'(bus_if.done), 64'd0);
    check("reset_result", 64'(bus_if.result), 64'd0);
    check("reset_rd_out", 64'(bus_if.rd_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Hand-computed expectations
    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd1,  1'b1, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  1'b1, 32'h4000_0000);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3,  1'b1, 32'h4000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd4,  1'b1, 32'hFFFF_FFFF);
    run_op(3'd5, 32'h1234,      32'd0,         5'd5,  1'b1, 32'hFFFF_FFFF);
    run_op(3'd7, 32'h1234,      32'd0,         5'd6,  1'b1, 32'h0000_1234);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  1'b1, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  1'b1, 32'h0000_0000);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 1'b1, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd11, 1'b1, 32'hFFFF_FFFD);
    run_op(3'd4, 32'h0000_0055, 32'd0,         5'd12, 1'b1, 32'hFFFF_FFFF);
    run_op(3'd6, 32'hFFFF_FF00, 32'd0,         5'd13, 1'b1, 32'hFFFF_FF00);

    run_abort(1'b0);
    run_abort(1'b1);
    run_op(3'd0, 32'd3, 32'd4, 5'd14, 1'b1, 32'd12);

    // Randomized ops against the reference model
    for (int i = 0; i < 48; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom_range(1, 31)), 1'b0, 32'd0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage. It is fed directly by the decode/execute pipeline register: operands are taken after forwarding, func3 and rd index come from that register. While an M-extension op is in flight it holds the front of the pipeline with a stall. It returns a result pulse to the execute-stage result mux.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITER, 32, iterations per mul/div operation; counter width is clog2(ITER)+1

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
flush  input  1  synchronous abort of the E-stage instruction (branch/jump taken)
in_valid  input  1  M-ext instruction present in E stage (opcode OP, funct7=0000001)
func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  XLEN  forwarded operand 1
rs2_val  input  XLEN  forwarded operand 2
rd_index  input  5  destination register
stall  output  1  hold PC, F/D and D/E registers (combinational)
done  output  1  one-cycle result-valid pulse
result  output  XLEN  result, valid when done=1
rd_out  output  5  destination of result

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (rst=0, async): state=IDLE, counter=0, all internal registers 0, result=0, rd_out=0, done=0.
- stall = (state==IDLE && in_valid && !flush) || state==CALC. It is 0 in DONE, so the D/E register advances at the end of the DONE cycle.
- IDLE, in_valid=1, flush=0 at a clock edge:
  - latch func3, rd_index, operand magnitudes and sign flags.
  - Fast path goes to DONE: DIV/DIVU/REM/REMU with rs2=0, or DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF.
  - Otherwise go to CALC with counter=0.
- CALC:
  - Exactly ITER iterations, one per cycle.
  - Mul: radix-2 shift-add on 32-bit magnitudes into a 64-bit unsigned product.
  - Div: restoring shift-subtract producing 32-bit quotient and remainder.
  - Go to DONE on the edge completing iteration ITER-1.
- DONE: done=1 for exactly one cycle; result and rd_out are valid; next state IDLE. in_valid is still high here (same instruction) and must not restart.
- Latency: start cycle + 32 CALC cycles, so done=1 in the 34th cycle after in_valid is first seen (cycle 33 counting from 0). Fast path gives done=1 in cycle 1.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitudes come from two's-complement negation.
  - The product is negated if the operand signs differ.
  - The quotient is negated if the signs differ. The remainder takes the dividend's sign.
- Result select:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Divide by zero: quotient=0xFFFFFFFF, remainder=rs1_val. This applies to both signed and unsigned forms.
- Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0.
- result and rd_out hold their last value until the next DONE. done is 0 outside DONE.
- flush=1:
  - In CALC: go to IDLE on the next edge; no done; stall drops the following cycle.
  - In IDLE: no start.
  - In DONE: ignored (result already committed).
  - flush has priority over in_valid.
- rst asserted mid-operation: immediate return to reset values; no done.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD (-3) -> stall=1 in cycles 0..32; done=1 in cycle 33 with result=0xFFFFFFEB; stall=0 in cycle 33; done=0 in cycle 34.
2. MULH and MULHU, each with rs1=rs2=0x80000000 -> MULH result=0x40000000; MULHU result=0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> result=0xFFFFFFFF.
3. DIVU rs1=0x1234, rs2=0 -> fast path, done in cycle 1, result=0xFFFFFFFF. REMU with the same operands -> result=0x1234.
4. DIV rs1=0x80000000, rs2=0xFFFFFFFF -> done in cycle 1, result=0x80000000. REM with the same operands -> result=0.
5. REM rs1=0xFFFFFFF9 (-7), rs2=2 -> result=0xFFFFFFFF. DIV with the same operands -> result=0xFFFFFFFD. Both take full 33-cycle latency.
6. DIV started, flush=1 in cycle 10 -> state IDLE in cycle 11, stall=0, done never asserted. Repeat with rst=0 in cycle 10 -> outputs 0 immediately. A following MUL 3*4 gives result=12 with normal latency.
